ifetch_pc_unit: RTL
===================

// Module: ifetch_pc_unit
// PURPOSE
//   Holds PC and IR for the multi-cycle MIPS core and is driven by the control FSM.
//   Computes next PC from NPCOp, fetches from instruction memory over a req/ack handshake,
//   loads IR and supplies Op/Func back to the controller.
//   Asserts stall until IR is valid, so the controller holds in Fetch.
//   Bounds each fetch with a timeout that substitutes a NOP and flags an error.
// PARAMETERS
//   RESET_PC   32'h0000_3000  PC value after reset
//   TIMEOUT    16             max cycles from imem_req to imem_ack (>=2)
//   NOP_INSTR  32'h0000_0000  word loaded into IR on timeout
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   asynchronous reset, active-low
//   PCWr        in   1   PC write enable from controller
//   IRWr        in   1   start fetch at current PC / IR write request
//   NPCOp       in   2   0=PC+4, 1=branch, 2=jump, 3=hold
//   imem_req    out  1   instruction memory request, held until ack
//   imem_addr   out  32  fetch address, word aligned, stable while imem_req=1
//   imem_rdata  in   32  instruction word, sampled when imem_ack=1
//   imem_ack    in   1   1-cycle response strobe
//   PC          out  32  current PC (post-increment value, used for jal link)
//   IR          out  32  instruction register
//   Op          out  6   IR[31:26]
//   Func        out  6   IR[5:0]
//   stall       out  1   1 while a fetch is outstanding
//   fetch_err   out  1   sticky error flag, cleared only by reset
// BEHAVIOUR
//   Reset (rst=0, async): PC=RESET_PC, IR=0, imem_req=0, imem_addr=RESET_PC, stall=0,
//   fetch_err=0, FSM=IDLE, timeout counter=0.
//   NPC, combinational, 32-bit, wraps modulo 2^32 with no overflow flag:
//     0: PC+4
//     1: PC + {{14{IR[15]}},IR[15:0],2'b00}; PC is already PC+4 of the branch
//     2: {PC[31:28],IR[25:0],2'b00}
//     3: PC
//   PC <= NPC on any edge with PCWr=1, independent of FSM state.
//   FSM states:
//     IDLE: on IRWr=1 -> imem_addr<=PC (value before any same-cycle PCWr update),
//           imem_req<=1, stall<=1, cnt<=0, go WAIT. So Fetch-state PCWr+IRWr fetch the old PC.
//     WAIT: imem_ack=1 -> IR<=imem_rdata, imem_req<=0, stall<=0, go IDLE.
//           Otherwise, if cnt==TIMEOUT-1 -> IR<=NOP_INSTR, fetch_err<=1, req<=0, stall<=0, go IDLE.
//           Otherwise cnt<=cnt+1.
//   Latency: ack in cycle N after the req cycle -> IR valid and stall=0 from cycle N+1.
//   With 1-cycle memory, IR is updated 2 edges after IRWr.
//   IR changes only on ack or timeout; stall is registered, with no comb path from ack.
//   Boundary conditions:
//     - IRWr=1 while in WAIT: ignored (no restart, addr unchanged) and fetch_err<=1.
//     - imem_ack=1 in IDLE: ignored, IR unchanged.
//     - ack and timeout on the same edge: ack wins, no error.
//     - IRWr together with ack in WAIT: the ack completes, the IRWr is a violation per the rule above.
//     - Reset mid-fetch: req drops asynchronously. A late ack after reset is ignored (IDLE).
//     - PC+4 from 32'hFFFF_FFFC gives 32'h0000_0000.
//   Op and Func are pure slices of IR.
// TESTING
//   1. Reset with rst=0: PC=0x3000, IR=0, req=0, stall=0, err=0. Release -> values hold.
//   2. 1-cycle memory fetch: PCWr=IRWr=1, NPCOp=0 at PC=0x3000 -> addr=0x3000, PC=0x3004,
//      rdata=0x3C010001 on ack -> IR=0x3C010001, Op=0x0F, stall low next cycle.
//   3. Branch: PC=0x3004, IR imm16=0xFFFF, NPCOp=1, PCWr -> PC=0x3000.
//      Jump: PC=0x3004, IR[25:0]=0x0000C03, NPCOp=2 -> PC=0x0000300C.
//   4. 5-cycle ack latency -> stall high exactly until the ack edge, addr stable throughout.
//      Extra IRWr mid-wait -> fetch_err=1, addr unchanged.
//   5. No ack for TIMEOUT=16 cycles -> IR=0, fetch_err=1, req=0.
//      A later ack is ignored, and the next fetch works normally.
//   6. Assert rst during WAIT -> req=0 immediately, PC=0x3000. An ack next cycle does not change IR.

Source files
------------

// File: rtl/ifetch_pc_unit.sv
// PC / IR holder for the multi-cycle MIPS core.
// Fetches over a req/ack handshake, bounded by a timeout.
module ifetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IRWr,
  input  logic [1:0]  NPCOp,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [5:0]  Op,
  output logic [5:0]  Func,
  output logic        stall,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_ir;
  logic [31:0]   r_addr;
  logic          r_req;
  logic          r_stall;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic [31:0]   w_npc;
  logic [31:0]   w_boff;
  logic [31:0]   w_ir_nxt;
  logic [31:0]   w_addr_nxt;
  logic          w_req_nxt;
  logic          w_stall_nxt;
  logic          w_err_nxt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_boff = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  // Next-PC selection; arithmetic wraps modulo 2^32
  always_comb begin
    w_npc = r_pc;
    unique case (NPCOp)
      2'd0: w_npc = r_pc + 32'd4;
      2'd1: w_npc = r_pc + w_boff;
      2'd2: w_npc = {r_pc[31:28], r_ir[25:0], 2'b00};
      2'd3: w_npc = r_pc;
    endcase
  end

  // PC register, written whenever the controller asks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (PCWr) begin
      r_pc <= w_npc;
    end
  end

  // Fetch FSM next-state and datapath updates
  always_comb begin
    w_state_nxt = r_state;
    w_ir_nxt    = r_ir;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_stall_nxt = r_stall;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (IRWr) begin
          w_addr_nxt  = r_pc;
          w_req_nxt   = 1'b1;
          w_stall_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IRWr) begin
          w_err_nxt = 1'b1;
        end
        if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_req_nxt   = 1'b0;
          w_stall_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CMAX) begin
          w_ir_nxt    = NOP_INSTR;
          w_err_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_stall_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    endcase
  end

  // Fetch FSM state and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ir    <= 32'h0;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
      r_stall <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ir    <= w_ir_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_stall <= w_stall_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign PC        = r_pc;
  assign IR        = r_ir;
  assign Op        = r_ir[31:26];
  assign Func      = r_ir[5:0];
  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign stall     = r_stall;
  assign fetch_err = r_err;

endmodule
